// File: rtl/pc_unit.sv
// pc_unit: program-counter stage with a hardware return-address stack.
//
// Ports:
//   clock       - system clock, all state updates on the rising edge
//   reset       - asynchronous active-low reset
//   pc_op       - 00 hold, 01 increment, 10 branch-class, 11 restart
//   flag        - ALU condition flag
//   cond        - 00 always, 01 if flag, 10 if !flag, 11 never
//   target      - absolute branch/call target
//   call        - qualifies pc_op=10 as a call
//   ret         - qualifies pc_op=10 as a return
//   pc          - current fetch address (registered)
//   taken       - one-cycle pulse after a load other than pc+1 or hold
//   depth       - number of valid return-address entries
//   stack_empty - depth == 0
//   stack_full  - depth == STACK_DEPTH
//   stack_err   - sticky overflow / underflow / illegal call+ret flag
module pc_unit #(
    parameter int unsigned PC_WIDTH     = 8,
    parameter int unsigned STACK_DEPTH  = 4,
    parameter int unsigned RESET_VECTOR = 0
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [1:0]                         pc_op,
    input  logic                               flag,
    input  logic [1:0]                         cond,
    input  logic [PC_WIDTH-1:0]                target,
    input  logic                               call,
    input  logic                               ret,
    output logic [PC_WIDTH-1:0]                pc,
    output logic                               taken,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stack_empty,
    output logic                               stack_full,
    output logic                               stack_err
);

    localparam int unsigned DW = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [1:0] OP_HOLD    = 2'b00;
    localparam logic [1:0] OP_INC     = 2'b01;
    localparam logic [1:0] OP_BRANCH  = 2'b10;
    localparam logic [1:0] OP_RESTART = 2'b11;

    logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];

    logic [PC_WIDTH-1:0] pc_plus1;
    logic                cond_ok;
    logic [PC_WIDTH-1:0] next_pc;
    logic [DW-1:0]       next_depth;
    logic                next_taken;
    logic                next_err;
    logic                do_push;
    logic [IW-1:0]       top_idx;
    logic [IW-1:0]       push_idx;

    assign pc_plus1 = pc + PC_WIDTH'(1);
    assign top_idx  = IW'(depth - DW'(1));
    assign push_idx = IW'(depth);

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            2'b00:   cond_ok = 1'b1;
            2'b01:   cond_ok = flag;
            2'b10:   cond_ok = ~flag;
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        next_pc    = pc;
        next_depth = depth;
        next_taken = 1'b0;
        next_err   = stack_err;
        do_push    = 1'b0;
        case (pc_op)
            OP_RESTART: begin
                next_pc    = PC_WIDTH'(RESET_VECTOR);
                next_depth = '0;
                next_err   = 1'b0;
                next_taken = 1'b1;
            end
            OP_HOLD: ;
            OP_INC: next_pc = pc_plus1;
            OP_BRANCH: begin
                if (call && ret) begin
                    next_pc  = pc_plus1;
                    next_err = 1'b1;
                end else if (!cond_ok) begin
                    next_pc = pc_plus1;
                end else if (ret) begin
                    if (depth != '0) begin
                        next_pc    = stack_mem[top_idx];
                        next_depth = depth - DW'(1);
                        next_taken = 1'b1;
                    end else begin
                        next_pc  = pc_plus1;
                        next_err = 1'b1;
                    end
                end else if (call) begin
                    next_pc    = target;
                    next_taken = 1'b1;
                    if (depth < DW'(STACK_DEPTH)) begin
                        do_push    = 1'b1;
                        next_depth = depth + DW'(1);
                    end else begin
                        next_err = 1'b1;
                    end
                end else begin
                    next_pc    = target;
                    next_taken = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Stack entries share the reset domain so an edge under reset never
    // lands a half-completed push.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc        <= PC_WIDTH'(RESET_VECTOR);
            taken     <= 1'b0;
            depth     <= '0;
            stack_err <= 1'b0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                stack_mem[i] <= '0;
            end
        end else begin
            pc        <= next_pc;
            taken     <= next_taken;
            depth     <= next_depth;
            stack_err <= next_err;
            if (do_push) begin
                stack_mem[push_idx] <= pc_plus1;
            end
        end
    end

    assign stack_empty = (depth == '0);
    assign stack_full  = (depth == DW'(STACK_DEPTH));

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic       clock;
    logic       reset;
    logic [1:0] pc_op;
    logic       flag;
    logic [1:0] cond;
    logic [7:0] target;
    logic       call;
    logic       ret;
    logic [7:0] pc;
    logic       taken;
    logic [2:0] depth;
    logic       stack_empty;
    logic       stack_full;
    logic       stack_err;

    int unsigned n_checks;
    int unsigned n_fail;

    // reference model state
    logic [7:0] m_pc;
    logic       m_taken;
    logic       m_err;
    logic [7:0] m_stack[$];

    pc_unit #(
        .PC_WIDTH    (8),
        .STACK_DEPTH (4),
        .RESET_VECTOR(0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pc_op      (pc_op),
        .flag       (flag),
        .cond       (cond),
        .target     (target),
        .call       (call),
        .ret        (ret),
        .pc         (pc),
        .taken      (taken),
        .depth      (depth),
        .stack_empty(stack_empty),
        .stack_full (stack_full),
        .stack_err  (stack_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 8'h00;
        m_taken = 1'b0;
        m_err   = 1'b0;
        m_stack.delete();
    endtask

    task automatic model_step(input logic [1:0] op, input logic f, input logic [1:0] c,
                              input logic [7:0] tgt, input logic cl, input logic rt);
        logic [7:0] nxt;
        logic       ok;
        nxt = m_pc + 8'd1;
        ok  = (c == 2'd0) || (c == 2'd1 && f) || (c == 2'd2 && !f);
        m_taken = 1'b0;
        case (op)
            2'd3: begin m_pc = 8'h00; m_stack.delete(); m_err = 1'b0; m_taken = 1'b1; end
            2'd0: ;
            2'd1: m_pc = nxt;
            default: begin
                if (cl && rt) begin
                    m_pc = nxt; m_err = 1'b1;
                end else if (!ok) begin
                    m_pc = nxt;
                end else if (rt) begin
                    if (m_stack.size() > 0) begin
                        m_pc = m_stack.pop_back(); m_taken = 1'b1;
                    end else begin
                        m_pc = nxt; m_err = 1'b1;
                    end
                end else begin
                    if (cl) begin
                        if (m_stack.size() < 4) m_stack.push_back(nxt);
                        else m_err = 1'b1;
                    end
                    m_pc = tgt; m_taken = 1'b1;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check("pc", 32'(pc), 32'(m_pc));
        check("taken", 32'(taken), 32'(m_taken));
        check("depth", 32'(depth), 32'(m_stack.size()));
        check("empty", 32'(stack_empty), 32'(m_stack.size() == 0));
        check("full", 32'(stack_full), 32'(m_stack.size() == 4));
        check("err", 32'(stack_err), 32'(m_err));
    endtask

    task automatic do_op(input logic [1:0] op, input logic f, input logic [1:0] c,
                         input logic [7:0] tgt, input logic cl, input logic rt);
        pc_op = op; flag = f; cond = c; target = tgt; call = cl; ret = rt;
        @(posedge clock);
        model_step(op, f, c, tgt, cl, rt);
        #1;
        compare_all();
    endtask

    task automatic br(input logic [7:0] tgt);
        do_op(2'b10, 1'b0, 2'b00, tgt, 1'b0, 1'b0);
    endtask
    task automatic do_call(input logic [7:0] tgt);
        do_op(2'b10, 1'b0, 2'b00, tgt, 1'b1, 1'b0);
    endtask
    task automatic do_ret();
        do_op(2'b10, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        pc_op = 2'b00; flag = 1'b0; cond = 2'b00; target = 8'h00; call = 1'b0; ret = 1'b0;
        model_reset();
        #12;
        compare_all();
        @(negedge clock);
        reset = 1'b1;

        // asynchronous reset mid-run
        br(8'h37);
        check("pre_rst_pc", 32'(pc), 32'h37);
        do_call(8'h37);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("async_rst_pc", 32'(pc), 32'h00);
        check("async_rst_taken", 32'(taken), 32'h0);
        compare_all();
        @(negedge clock);
        reset = 1'b1;
        repeat (3) do_op(2'b01, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
        check("inc3_pc", 32'(pc), 32'h03);

        // conditional branch
        br(8'h10);
        do_op(2'b10, 1'b0, 2'b01, 8'h80, 1'b0, 1'b0);
        check("cond_nt_pc", 32'(pc), 32'h11);
        do_op(2'b10, 1'b1, 2'b01, 8'h80, 1'b0, 1'b0);
        check("cond_t_pc", 32'(pc), 32'h80);
        check("cond_t_taken", 32'(taken), 32'h1);
        do_op(2'b10, 1'b1, 2'b11, 8'h80, 1'b0, 1'b0);
        check("never_pc", 32'(pc), 32'h81);
        check("taken_pulse", 32'(taken), 32'h0);

        // call/return nest
        br(8'h20);
        do_call(8'h40);
        do_call(8'h60);
        check("nest_depth", 32'(depth), 32'h2);
        do_ret();
        check("ret1_pc", 32'(pc), 32'h41);
        do_ret();
        check("ret2_pc", 32'(pc), 32'h21);
        check("ret2_empty", 32'(stack_empty), 32'h1);

        // overflow
        do_op(2'b11, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) do_call(8'(i * 16));
        check("ovf_depth", 32'(depth), 32'h4);
        check("ovf_err", 32'(stack_err), 32'h1);
        check("ovf_pc", 32'(pc), 32'h50);
        do_ret(); check("ovf_ret1", 32'(pc), 32'h31);
        do_ret(); check("ovf_ret2", 32'(pc), 32'h21);
        do_ret(); check("ovf_ret3", 32'(pc), 32'h11);
        do_ret(); check("ovf_ret4", 32'(pc), 32'h01);

        // underflow / illegal / wrap
        do_op(2'b11, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
        br(8'h05);
        do_ret();
        check("unf_pc", 32'(pc), 32'h06);
        check("unf_err", 32'(stack_err), 32'h1);
        do_op(2'b11, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
        check("restart_err", 32'(stack_err), 32'h0);
        do_op(2'b10, 1'b0, 2'b00, 8'h44, 1'b1, 1'b1);
        check("illegal_pc", 32'(pc), 32'h01);
        check("illegal_err", 32'(stack_err), 32'h1);
        br(8'hFF);
        do_op(2'b01, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
        check("wrap_pc", 32'(pc), 32'h00);
        br(8'hFF);
        do_call(8'h10);
        do_ret();
        check("wrap_ret_pc", 32'(pc), 32'h00);

        // randomized run against the model
        for (int i = 0; i < 600; i++) begin
            logic [1:0] op;
            op = (($urandom_range(0, 19)) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) op = 2'b10;
            do_op(op, 1'($urandom), 2'($urandom), 8'($urandom),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
